// File: rtl/fp_mul_seq.sv
// Sequential floating-point multiplier: radix-2 shift-add mantissa product, RNE rounding, flush-to-zero.
// One operation in flight; special operands bypass the multiply and finish in the cycle after accept.
module fp_mul_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [EXP_W+MAN_W:0]       dataa,
  input  logic [EXP_W+MAN_W:0]       datab,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [EXP_W+MAN_W:0]       result,
  output logic [3:0]                 flags
);
  localparam int M    = MAN_W + 1;
  localparam int AW   = 2 * M;
  localparam int EW   = EXP_W + 2;
  localparam int CW   = $clog2(M + 1);
  localparam int BIAS = (1 << (EXP_W - 1)) - 1;
  localparam logic signed [EW-1:0] EXP_MAX = EW'((1 << EXP_W) - 1);

  typedef enum logic [2:0] {IDLE, MUL, NORM, RND, DONE} state_t;
  state_t state, state_nxt;

  logic [AW-1:0]          acc;
  logic [M-1:0]           mcand;
  logic [CW-1:0]          cnt;
  logic signed [EW-1:0]   exp_r;
  logic                   sign_r;
  logic [MAN_W-1:0]       man_r;
  logic                   grd, stk;

  // operand decode
  logic                   sa, sb;
  logic [EXP_W-1:0]       ea, eb;
  logic [MAN_W-1:0]       fa, fb;
  logic                   a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, special;
  logic [EXP_W+MAN_W:0]   spec_res;
  logic [3:0]             spec_flags;
  logic signed [EW-1:0]   e_sum;

  assign {sa, ea, fa} = dataa;
  assign {sb, eb, fb} = datab;
  assign a_zero  = (ea == '0);
  assign b_zero  = (eb == '0);
  assign a_nan   = (&ea) && (|fa);
  assign b_nan   = (&eb) && (|fb);
  assign a_inf   = (&ea) && !(|fa);
  assign b_inf   = (&eb) && !(|fb);
  assign special = a_zero || b_zero || a_inf || b_inf || a_nan || b_nan;
  assign e_sum   = EW'(ea) + EW'(eb) - EW'(BIAS);

  always_comb begin
    spec_res   = {sa ^ sb, {(EXP_W+MAN_W){1'b0}}};
    spec_flags = 4'b0000;
    if (a_nan || b_nan) begin
      spec_res = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
    end else if ((a_inf && b_zero) || (a_zero && b_inf)) begin
      spec_res   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
      spec_flags = 4'b1000;
    end else if (a_inf || b_inf) begin
      spec_res = {sa ^ sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end
  end

  // one multiplier bit per cycle: multiplier sits in acc low half and shifts out
  logic [M:0] step_sum;
  assign step_sum = {1'b0, acc[AW-1:M]} + (acc[0] ? {1'b0, mcand} : {(M+1){1'b0}});

  logic [MAN_W-1:0]     n_man;
  logic                 n_g, n_s;
  logic signed [EW-1:0] n_exp;
  always_comb begin
    n_man = acc[AW-3 -: MAN_W];
    n_g   = acc[MAN_W-1];
    n_s   = |acc[MAN_W-2:0];
    n_exp = exp_r;
    if (acc[AW-1]) begin
      n_man = acc[AW-2 -: MAN_W];
      n_g   = acc[MAN_W];
      n_s   = |acc[MAN_W-1:0];
      n_exp = exp_r + EW'(1);
    end
  end

  logic                 r_inc, r_carry;
  logic [MAN_W-1:0]     r_man;
  logic signed [EW-1:0] r_exp;
  logic [EXP_W+MAN_W:0] r_res;
  logic [3:0]           r_flags;
  always_comb begin
    r_inc            = grd && (stk || man_r[0]);
    {r_carry, r_man} = {1'b0, man_r} + {{MAN_W{1'b0}}, r_inc};
    r_exp            = r_carry ? exp_r + EW'(1) : exp_r;
    r_res            = {sign_r, r_exp[EXP_W-1:0], r_man};
    r_flags          = {3'b000, grd || stk};
    if (r_exp >= EXP_MAX) begin
      r_res   = {sign_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      r_flags = 4'b0101;
    end else if (r_exp[EW-1] || (r_exp == '0)) begin
      r_res   = {sign_r, {(EXP_W+MAN_W){1'b0}}};
      r_flags = 4'b0011;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = special ? DONE : MUL;
      MUL:     if (cnt == CW'(M - 1)) state_nxt = NORM;
      NORM:    state_nxt = RND;
      RND:     state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      acc    <= '0;
      mcand  <= '0;
      cnt    <= '0;
      exp_r  <= '0;
      sign_r <= 1'b0;
      man_r  <= '0;
      grd    <= 1'b0;
      stk    <= 1'b0;
      result <= '0;
      flags  <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          sign_r <= sa ^ sb;
          exp_r  <= e_sum;
          mcand  <= {1'b1, fa};
          acc    <= {{M{1'b0}}, 1'b1, fb};
          cnt    <= '0;
          if (special) begin
            result <= spec_res;
            flags  <= spec_flags;
          end
        end
        MUL: begin
          acc <= {step_sum, acc[M-1:1]};
          cnt <= cnt + CW'(1);
        end
        NORM: begin
          man_r <= n_man;
          grd   <= n_g;
          stk   <= n_s;
          exp_r <= n_exp;
        end
        RND: begin
          result <= r_res;
          flags  <= r_flags;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_mul_seq.sv
// Directed bench for fp_mul_seq: single-precision vector table plus handshake/reset/half-precision sequences.
module tb_fp_mul_seq;
  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] dataa, datab, result;
  logic [3:0]  flags;

  logic        h_in_valid, h_in_ready, h_out_valid, h_out_ready;
  logic [15:0] h_dataa, h_datab, h_result;
  logic [3:0]  h_flags;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fp_mul_seq #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .dataa(dataa), .datab(datab), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flags(flags)
  );

  fp_mul_seq #(.EXP_W(5), .MAN_W(10)) dut_h (
    .clk(clk), .reset(reset), .in_valid(h_in_valid), .in_ready(h_in_ready),
    .dataa(h_dataa), .datab(h_datab), .out_valid(h_out_valid), .out_ready(h_out_ready),
    .result(h_result), .flags(h_flags)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] r, output logic [3:0] f, output int lat);
    dataa = a; datab = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    r = result; f = flags;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  typedef struct {
    logic [31:0] a, b, r;
    logic [3:0]  f;
    int          lat;
  } vec_t;

  vec_t vt[14];

  initial begin
    logic [31:0] r;
    logic [3:0]  f;
    int          lat, cnt;

    // lat = clock edges after the accept edge until out_valid is seen high
    vt[0]  = '{32'h40000000, 32'h40400000, 32'h40C00000, 4'b0000, 26};
    vt[1]  = '{32'hC0000000, 32'h40400000, 32'hC0C00000, 4'b0000, 26};
    vt[2]  = '{32'h3FC00000, 32'h3FC00000, 32'h40100000, 4'b0000, 26};
    vt[3]  = '{32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001, 26};
    vt[4]  = '{32'h7F000000, 32'h40000000, 32'h7F800000, 4'b0101, 26};
    vt[5]  = '{32'h00800000, 32'h3F000000, 32'h00000000, 4'b0011, 26};
    vt[6]  = '{32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000, 0};
    vt[7]  = '{32'h80000000, 32'h40000000, 32'h80000000, 4'b0000, 0};
    vt[8]  = '{32'h3F800001, 32'h3FC00000, 32'h3FC00002, 4'b0001, 26};
    vt[9]  = '{32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE, 4'b0001, 26};
    vt[10] = '{32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000, 0};
    vt[11] = '{32'h7FC00001, 32'hFF800000, 32'h7FC00000, 4'b0000, 0};
    vt[12] = '{32'h00000001, 32'hC0000000, 32'h80000000, 4'b0000, 0};
    vt[13] = '{32'hFF800000, 32'h80000000, 32'h7FC00000, 4'b1000, 0};

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; dataa = '0; datab = '0;
    h_in_valid = 1'b0; h_out_ready = 1'b0; h_dataa = '0; h_datab = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    chk("reset out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset result", result, 32'd0);
    chk("reset flags", {28'd0, flags}, 32'd0);

    for (int i = 0; i < 14; i++) begin
      run_op(vt[i].a, vt[i].b, r, f, lat);
      chk($sformatf("vec%0d result", i), r, vt[i].r);
      chk($sformatf("vec%0d flags", i), {28'd0, f}, {28'd0, vt[i].f});
      chk($sformatf("vec%0d latency", i), lat, vt[i].lat);
    end

    // held output with upstream poking in_valid while busy
    dataa = 32'h40000000; datab = 32'h40400000; in_valid = 1'b1;
    @(posedge clk); #1;
    dataa = 32'h7F800000; datab = 32'h3F800000;
    repeat (10) begin @(posedge clk); #1; end
    in_valid = 1'b0;
    cnt = 0;
    while (!out_valid && cnt < 100) begin @(posedge clk); #1; cnt++; end
    chk("hold out_valid reached", {31'd0, out_valid}, 32'd1);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("hold%0d result", k), result, 32'h40C00000);
      chk($sformatf("hold%0d in_ready", k), {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
    end
    chk("hold out_valid after stall", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("taken in_ready", {31'd0, in_ready}, 32'd1);
    chk("taken out_valid", {31'd0, out_valid}, 32'd0);

    // reset in the middle of the multiply
    dataa = 32'h40000000; datab = 32'h40400000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort in_ready", {31'd0, in_ready}, 32'd1);
    chk("abort result", result, 32'd0);
    chk("abort flags", {28'd0, flags}, 32'd0);
    cnt = 0;
    repeat (40) begin
      if (out_valid) cnt++;
      @(posedge clk); #1;
    end
    chk("abort no out_valid", cnt, 0);

    // half-precision instance: 2 * 3 = 6
    h_dataa = 16'h4000; h_datab = 16'h4200; h_in_valid = 1'b1;
    @(posedge clk); #1;
    h_in_valid = 1'b0;
    lat = 0;
    while (!h_out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    chk("half result", {16'd0, h_result}, 32'h00004600);
    chk("half flags", {28'd0, h_flags}, 32'd0);
    chk("half latency", lat, 13);
    h_out_ready = 1'b1;
    @(posedge clk); #1;
    h_out_ready = 1'b0;
    chk("half in_ready", {31'd0, h_in_ready}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
